// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- parametrised universal shift register with a fill tracker
// and an on-the-fly pattern detector.
//
// Purpose:
//   WIDTH-bit register that can hold, shift left, shift right or parallel load.
//   A fill counter tracks how many fresh bits have entered since reset, and
//   'valid' goes high once every bit position has been filled.
//   Every shift that leaves q equal to PATTERN, with the register full,
//   raises a one-cycle 'match' pulse.
//
// Optional feature (macro UNIV_SHIFT_REG_MATCH_CNT_EN):
//   Defined   : match_cnt is a saturating count of match pulses.
//   Undefined : the counter is not built and match_cnt is tied to 0.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   en         in   1      clock enable; 0 holds all state
//   mode       in   2      00 hold, 01 shift left, 10 shift right, 11 load
//   a          in   1      serial data in
//   d          in   WIDTH  parallel load data
//   q          out  WIDTH  register contents
//   so         out  1      serial out: q[WIDTH-1] in mode 01, else q[0]
//   valid      out  1      register fully populated since reset
//   match      out  1      one-cycle pulse when a shift produces PATTERN
//   match_cnt  out  CNT_W  saturating count of match pulses
module univ_shift_reg #(
  parameter int unsigned            WIDTH   = 3,
  parameter logic [WIDTH-1:0]       PATTERN = WIDTH'(5),
  parameter int unsigned            CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             valid,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("univ_shift_reg: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  q_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic              valid_reg;
  logic              match_reg;
  logic              match_next;

  // Next-state for q and the fill counter; match is only ever raised by a
  // shift, never by a load or a hold.
  always_comb begin
    q_next     = q_reg;
    fill_next  = fill_reg;
    match_next = 1'b0;
    case (mode)
      MODE_LEFT, MODE_RIGHT: begin
        if (mode == MODE_LEFT) begin
          q_next = {q_reg[WIDTH-2:0], a};
        end else begin
          q_next = {a, q_reg[WIDTH-1:1]};
        end
        // Saturate at WIDTH; direction changes keep accumulating fill.
        fill_next  = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
        match_next = (q_next == PATTERN) && (fill_next == FILL_FULL);
      end
      MODE_LOAD: begin
        q_next    = d;
        fill_next = FILL_FULL;
      end
      default: begin
        // MODE_HOLD: nothing changes, match drops.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= '0;
      fill_reg  <= '0;
      valid_reg <= 1'b0;
      match_reg <= 1'b0;
    end else if (en) begin
      q_reg     <= q_next;
      fill_reg  <= fill_next;
      valid_reg <= (fill_next == FILL_FULL);
      match_reg <= match_next;
    end else begin
      match_reg <= 1'b0;
    end
  end

`ifdef UNIV_SHIFT_REG_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Counts exactly the cycles where match_reg is being set to 1, and sticks
  // at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (en && match_next && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign match_cnt = cnt_reg;
`else
  assign match_cnt = '0;
`endif

  assign q     = q_reg;
  assign valid = valid_reg;
  assign match = match_reg;
  assign so    = (mode == MODE_LEFT) ? q_reg[WIDTH-1] : q_reg[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=3, PATTERN=3'b101).
// Two instances share the stimulus: u_dut with CNT_W=8 and u_sat with
// CNT_W=2 for the counter-saturation case.
module tb_univ_shift_reg;

`ifdef UNIV_SHIFT_REG_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       a;
  logic [2:0] d;
  logic [2:0] q;
  logic       so;
  logic       valid;
  logic       match;
  logic [7:0] match_cnt;
  logic [2:0] sat_q;
  logic       sat_so;
  logic       sat_valid;
  logic       sat_match;
  logic [1:0] sat_cnt;

  int checks;
  int passes;

  univ_shift_reg #(.WIDTH(3), .PATTERN(3'b101), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .d(d),
    .q(q), .so(so), .valid(valid), .match(match), .match_cnt(match_cnt)
  );

  univ_shift_reg #(.WIDTH(3), .PATTERN(3'b101), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .d(d),
    .q(sat_q), .so(sat_so), .valid(sat_valid), .match(sat_match),
    .match_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic s, input logic [2:0] dd);
    rst = r; en = e; mode = m; a = s; d = dd;
    @(posedge clk);
    #1;
    $display("txn rst=%0b en=%0b mode=%0b a=%0b d=%b -> q=%b so=%0b valid=%0b match=%0b cnt=%0d sat_cnt=%0d",
             r, e, m, s, dd, q, so, valid, match, match_cnt, sat_cnt);
  endtask

  task automatic expect_state(input string tag, input logic [2:0] eq,
                              input logic ev, input logic em,
                              input logic [7:0] ecnt);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".valid"}, 32'(valid), 32'(ev));
    check({tag, ".match"}, 32'(match), 32'(em));
    check({tag, ".cnt"}, 32'(match_cnt), CNT_EN ? 32'(ecnt) : 32'd0);
  endtask

  logic       sat_bits   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       sat_match_e[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] sat_cnt_e  [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [7:0] big_cnt_e  [9] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4};

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1; en = 1'b0; mode = 2'b00; a = 1'b0; d = 3'b000;

    // 1. Reset and fill gating
    step(1'b1, 1'b1, 2'b01, 1'b1, 3'b111);
    step(1'b1, 1'b0, 2'b11, 1'b1, 3'b111);
    expect_state("reset", 3'b000, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'b000);
    expect_state("fill1", 3'b001, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 2'b01, 1'b0, 3'b000);
    expect_state("fill2", 3'b010, 1'b0, 1'b0, 8'd0);
    check("fill2.so", 32'(so), 32'd0);
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'b000);
    expect_state("fill3", 3'b101, 1'b1, 1'b1, 8'd1);
    check("fill3.so", 32'(so), 32'd1);

    // 2. Overlapping matches
    step(1'b0, 1'b1, 2'b01, 1'b0, 3'b000);
    expect_state("ovl1", 3'b010, 1'b1, 1'b0, 8'd1);
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'b000);
    expect_state("ovl2", 3'b101, 1'b1, 1'b1, 8'd2);

    // 3. Load, shift right, serial out
    step(1'b0, 1'b1, 2'b11, 1'b0, 3'b110);
    expect_state("load", 3'b110, 1'b1, 1'b0, 8'd2);
    check("load.so", 32'(so), 32'd0);
    step(1'b0, 1'b1, 2'b10, 1'b1, 3'b000);
    expect_state("shr", 3'b111, 1'b1, 1'b0, 8'd2);
    check("shr.so", 32'(so), 32'd1);

    // 4. Enable low and mode hold
    step(1'b0, 1'b1, 2'b11, 1'b0, 3'b101);
    expect_state("load101", 3'b101, 1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b01, i[0], 3'b000);
      expect_state("en_off", 3'b101, 1'b1, 1'b0, 8'd2);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 2'b00, ~i[0], 3'b000);
      expect_state("hold", 3'b101, 1'b1, 1'b0, 8'd2);
    end

    // 5. Reset mid-operation
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'b000);
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'b000);
    expect_state("pre_rst", 3'b111, 1'b1, 1'b0, 8'd2);
    step(1'b1, 1'b1, 2'b01, 1'b1, 3'b000);
    expect_state("mid_rst", 3'b000, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'b000);
    expect_state("post1", 3'b001, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 2'b01, 1'b0, 3'b000);
    expect_state("post2", 3'b010, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 2'b01, 1'b1, 3'b000);
    expect_state("post3", 3'b101, 1'b1, 1'b1, 8'd1);

    // 6. Saturation on the CNT_W=2 instance
    step(1'b1, 1'b1, 2'b00, 1'b0, 3'b000);
    check("sat_rst.cnt", 32'(sat_cnt), 32'd0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 2'b01, sat_bits[i], 3'b000);
      check($sformatf("sat%0d.match", i), 32'(sat_match), 32'(sat_match_e[i]));
      check($sformatf("sat%0d.cnt", i), 32'(sat_cnt),
            CNT_EN ? 32'(sat_cnt_e[i]) : 32'd0);
      check($sformatf("sat%0d.big", i), 32'(match_cnt),
            CNT_EN ? 32'(big_cnt_e[i]) : 32'd0);
    end
    step(1'b0, 1'b1, 2'b00, 1'b0, 3'b000);
    check("sat_hold.cnt", 32'(sat_cnt), CNT_EN ? 32'd3 : 32'd0);
    check("sat_hold.match", 32'(sat_match), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
